// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, FSM encoding and the magnitude helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0100;
    localparam logic [3:0] ALU_DIV = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Widest operand abs_w() can handle; callers zero-extend and cast back.
    localparam int MAXW = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Magnitude of a two's complement value whose sign bit is passed separately.
    function automatic logic [MAXW-1:0] abs_w(input logic [MAXW-1:0] x, input logic sign);
        return sign ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d, d_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q, div_q;
    logic [WIDTH:0]   sum, shl, diff;

    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, d_q};
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, d_q};
        lo_d = lo_q;
        hi_d = hi_q;
        if (div_q) begin
            hi_d = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else if (lo_q[0]) begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q  <= '0;
            hi_q  <= '0;
            d_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else if (load) begin
            lo_q  <= op_a;
            hi_q  <= '0;
            d_q   <= op_b;
            cnt_q <= '0;
            run_q <= 1'b1;
            div_q <= is_div;
        end else if (run_q) begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) run_q <= 1'b0;
        end
    end

    // Drops during the final step so the owner can leave its wait state on the same edge.
    assign busy = run_q && (cnt_q != LAST);
    assign lo   = lo_q;
    assign hi   = hi_q;

endmodule

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative signed MUL/DIV.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    state_e             state_q, state_d;
    logic               neg_q, a_neg_q, is_div_q;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic               zero_q, zero_d, dbz_q, dbz_d, upd;
    logic               md_load, md_busy;
    logic [WIDTH-1:0]   md_lo, md_hi, mag_a, mag_b;
    logic [WIDTH-1:0]   s_lo, s_hi;
    logic               s_dbz;
    logic [2*WIDTH-1:0] prod;

    assign mag_a = WIDTH'(abs_w(MAXW'(a), a[WIDTH-1]));
    assign mag_b = WIDTH'(abs_w(MAXW'(b), b[WIDTH-1]));
    assign prod  = {md_hi, md_lo};

    muldiv_iter #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (md_load),
        .is_div (ALU_control == ALU_DIV),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .busy   (md_busy),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    // Single-cycle results; the DIV arm only matters for the divide-by-zero shortcut.
    always_comb begin
        s_lo  = '0;
        s_hi  = '0;
        s_dbz = 1'b0;
        case (ALU_control)
            ALU_ADD: s_lo = a + b;
            ALU_SUB: s_lo = a - b;
            ALU_AND: s_lo = a & b;
            ALU_OR:  s_lo = a | b;
            ALU_SLT: s_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_NOR: s_lo = ~(a | b);
            ALU_DIV: begin
                s_lo  = '1;
                s_hi  = a;
                s_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        md_load = 1'b0;
        upd     = 1'b0;
        res_d   = res_q;
        hi_d    = hi_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: if (start) begin
                if (ALU_control == ALU_MUL || (ALU_control == ALU_DIV && b != '0)) begin
                    md_load = 1'b1;
                    state_d = (ALU_control == ALU_MUL) ? ST_MUL : ST_DIV;
                end else begin
                    state_d = ST_DONE;
                    upd     = 1'b1;
                    res_d   = s_lo;
                    hi_d    = s_hi;
                    dbz_d   = s_dbz;
                end
            end
            ST_MUL, ST_DIV: if (!md_busy) state_d = ST_FIX;
            ST_FIX: begin
                state_d = ST_DONE;
                upd     = 1'b1;
                dbz_d   = 1'b0;
                if (is_div_q) begin
                    res_d = neg_q ? -md_lo : md_lo;
                    hi_d  = a_neg_q ? -md_hi : md_hi;
                end else begin
                    {hi_d, res_d} = neg_q ? -prod : prod;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        zero_d = upd ? (res_d == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            res_q    <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            if (md_load) begin
                neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                a_neg_q  <= a[WIDTH-1];
                is_div_q <= (ALU_control == ALU_DIV);
            end
        end
    end

    assign result      = res_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench: driver pushes model results, monitor pops and checks on every done.
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   ALU_control;
    logic [W-1:0] a, b;
    logic [W-1:0] result, result_hi;
    logic         zero, busy, done, div_by_zero;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ALU_control (ALU_control),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        dbz;
        int          lat;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.lo = 32'd0; e.hi = 32'd0; e.dbz = 1'b0; e.lat = 1; e.due = 0;
        case (op)
            4'b0010: e.lo = x + y;
            4'b0110: e.lo = x - y;
            4'b0000: e.lo = x & y;
            4'b0001: e.lo = x | y;
            4'b0111: e.lo = (sx < sy) ? 32'd1 : 32'd0;
            4'b1100: e.lo = ~(x | y);
            4'b0100: begin
                p = sx * sy;
                e.lo = p[31:0]; e.hi = p[63:32]; e.lat = W + 2;
            end
            4'b0101: begin
                if (y == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    e.lo = q[31:0]; e.hi = r[31:0]; e.lat = W + 2;
                end
            end
            default: ;
        endcase
        e.z = (e.lo == 32'd0);
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                me = exp_q.pop_front();
                chk("result", 64'(result), 64'(me.lo));
                chk("result_hi", 64'(result_hi), 64'(me.hi));
                chk("zero", 64'(zero), 64'(me.z));
                chk("div_by_zero", 64'(div_by_zero), 64'(me.dbz));
                chk("latency", 64'(cyc), 64'(me.due));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("idle_timeout", 64'(k), 64'd0);
        ALU_control = op; a = x; b = y; start = 1'b1;
        e = model(op, x, y);
        e.due = cyc + e.lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            5: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] codes [9] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                              4'b1100, 4'b0100, 4'b0101, 4'b1111};

    initial begin
        int snap;
        rst_n = 1'b0; start = 1'b0; ALU_control = 4'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_result_hi", 64'(result_hi), 64'd0);
        chk("rst_flags", 64'({zero, busy, done, div_by_zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
        issue(4'b0110, 32'd5, 32'd5);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        issue(4'b1100, 32'd0, 32'd0);
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(4'b0100, 32'hFFFF_FFFD, 32'd7);
        issue(4'b0100, 32'h0001_0000, 32'h0001_0000);
        issue(4'b0101, 32'hFFFF_FFF9, 32'd2);
        issue(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'b0101, 32'd9, 32'd0);
        drain();

        for (int i = 0; i < 60; i++)
            issue(codes[$urandom_range(0, 8)], rnd_val(), rnd_val());
        drain();

        // A start pulsed mid-MUL must not queue a second operation.
        snap = done_cnt;
        issue(4'b0100, 32'd123, 32'hFFFF_FF00);
        repeat (3) @(negedge clk);
        chk("busy_mid_mul", 64'(busy), 64'd1);
        start = 1'b1; ALU_control = 4'b0010; a = 32'd1; b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);
        chk("single_done", 64'(done_cnt), 64'(snap + 1));

        // Reset part-way through a DIV aborts it silently.
        issue(4'b0101, 32'd100000, 32'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_result_hi", 64'(result_hi), 64'd0);
        chk("abort_flags", 64'({zero, busy, done, div_by_zero}), 64'd0);
        exp_q.delete();
        snap = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 64'(done_cnt), 64'(snap));
        issue(4'b0010, 32'd40, 32'd2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
